// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int index_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - clog2(sets);
  endfunction

  function automatic int age_w(input int ways);
    return clog2(ways);
  endfunction

endpackage

// File: rtl/lru_age_tracker.sv
// True-LRU age array for all sets; age 0 = most recent, WAYS-1 = victim.
module lru_age_tracker
  import cache_pkg::*;
#(
  parameter int SETS = 4,
  parameter int WAYS = 2,
  localparam int INDEX_W = index_w(SETS),
  localparam int AGE_W = age_w(WAYS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] set_idx,
  input  logic [AGE_W-1:0]   touch_way,
  input  logic               update,
  output logic [AGE_W-1:0]   victim
);

  logic [AGE_W-1:0] age [SETS][WAYS];
  logic [AGE_W-1:0] touched_age;

  assign touched_age = age[set_idx][touch_way];

  // Ages of one set stay a permutation: the touched way goes to 0, younger ones shift up.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (update) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == touch_way)
          age[set_idx][w] <= '0;
        else if (age[set_idx][w] < touched_age)
          age[set_idx][w] <= age[set_idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set_idx][w] == AGE_W'(WAYS - 1))
        victim = AGE_W'(w);
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way write-back, write-allocate cache with memory writeback/refill sequencing.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
//
// state     | meaning
// IDLE      | req_ready high, waiting for a CPU request
// LOOKUP    | tag compare, pick hit way or victim
// WRITEBACK | victim dirty: write it to memory, wait for mem_ack
// REFILL    | read miss: fetch the word, wait for mem_ack
// RESPOND   | one-cycle response, write data stored, LRU updated
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3,
  parameter int SETS = 4,
  parameter int WAYS = 2,
  localparam int INDEX_W = index_w(SETS),
  localparam int TAG_W = tag_w(ADDR_W, SETS),
  localparam int AGE_W = age_w(WAYS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [AGE_W-1:0]  lru_way,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic              wren_q;
  logic [DATA_W-1:0] wdata_q;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag_q;

  logic              vld [SETS][WAYS];
  logic              drt [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];

  logic             hit_any, inv_any, vict_dirty;
  logic [AGE_W-1:0] hit_way, inv_way, vict_way, sel_way, lru_victim;
  logic [AGE_W-1:0] way_q;
  logic             hit_q, valid_q, dirty_q;

  assign idx   = addr_q[INDEX_W-1:0];
  assign tag_q = addr_q[ADDR_W-1:INDEX_W];

  lru_age_tracker #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clock     (clock),
    .reset     (reset),
    .set_idx   (idx),
    .touch_way (way_q),
    .update    (state == RESPOND),
    .victim    (lru_victim)
  );

  // Descending scan leaves the lowest matching index selected.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (vld[idx][w] && tag_mem[idx][w] == tag_q) begin
        hit_any = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!vld[idx][w]) begin
        inv_any = 1'b1;
        inv_way = AGE_W'(w);
      end
    end
    vict_way   = inv_any ? inv_way : lru_victim;
    sel_way    = hit_any ? hit_way : vict_way;
    vict_dirty = vld[idx][vict_way] && drt[idx][vict_way];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (req_valid) state_nx = LOOKUP;
      LOOKUP: begin
        if (hit_any)         state_nx = RESPOND;
        else if (vict_dirty) state_nx = WRITEBACK;
        else if (!wren_q)    state_nx = REFILL;
        else                 state_nx = RESPOND;
      end
      WRITEBACK: if (mem_ack) state_nx = wren_q ? RESPOND : REFILL;
      REFILL:    if (mem_ack) state_nx = RESPOND;
      RESPOND:   state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        addr_q  <= address;
        wren_q  <= wren;
        wdata_q <= wdata;
      end
      if (state == LOOKUP) begin
        way_q   <= sel_way;
        hit_q   <= hit_any;
        valid_q <= hit_any || vld[idx][vict_way];
        dirty_q <= !hit_any && vict_dirty;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          vld[s][w] <= 1'b0;
          drt[s][w] <= 1'b0;
        end
    end else if (state == REFILL && mem_ack) begin
      vld[idx][way_q] <= 1'b1;
      drt[idx][way_q] <= 1'b0;
    end else if (state == RESPOND && wren_q) begin
      vld[idx][way_q] <= 1'b1;
      drt[idx][way_q] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == REFILL && mem_ack) begin
        tag_mem[idx][way_q]  <= tag_q;
        data_mem[idx][way_q] <= mem_rdata;
      end else if (state == RESPOND && wren_q) begin
        tag_mem[idx][way_q]  <= tag_q;
        data_mem[idx][way_q] <= wdata_q;
      end
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = 1'b0;
    rdata      = '0;
    hit        = 1'b0;
    valid_o    = 1'b0;
    dirty_o    = 1'b0;
    lru_way    = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_mem[idx][way_q], idx};
        mem_wdata = data_mem[idx][way_q];
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
      end
      RESPOND: begin
        resp_valid = 1'b1;
        hit        = hit_q;
        valid_o    = valid_q;
        dirty_o    = dirty_q;
        lru_way    = way_q;
        rdata      = wren_q ? wdata_q : data_mem[idx][way_q];
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == RESPOND) begin
      if (hit_q && hit_cnt != 16'hFFFF)    hit_cnt  <= hit_cnt + 16'd1;
      if (!hit_q && miss_cnt != 16'hFFFF)  miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed and randomized bench for assoc_cache against a timestamp-LRU reference model.
module tb_assoc_cache;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 3;
  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int NADDR = 1 << ADDR_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic wren = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic req_ready, resp_valid, hit, valid_o, dirty_o, mem_req, mem_we;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [0:0] lru_way;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0] hit_count, miss_count;

  always #5 clock = ~clock;

  assoc_cache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .wren(wren), .address(address), .wdata(wdata), .resp_valid(resp_valid),
    .rdata(rdata), .hit(hit), .valid_o(valid_o), .dirty_o(dirty_o), .lru_way(lru_way),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference model: per-way last-use timestamps; victim = lowest invalid way, else oldest stamp.
  typedef struct { bit hit; bit vo; bit dop; int way; int rdata; } resp_t;
  typedef struct { bit we; int addr; int data; } mop_t;
  resp_t exp_q[$];
  mop_t  mop_q[$];

  logic [DATA_W-1:0] mem [NADDR];
  logic [DATA_W-1:0] ref_mem [NADDR];
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  int m_data  [SETS][WAYS];
  int m_stamp [SETS][WAYS];
  int now, m_hits, m_misses;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_tag[s][w]   = 0;
        m_data[s][w]  = 0;
        m_stamp[s][w] = -w;
      end
    now = 0;
    m_hits = 0;
    m_misses = 0;
    exp_q.delete();
    mop_q.delete();
  endtask

  task automatic model_access(input bit we, input int a, input int d, output bit eh);
    int s, t, way;
    resp_t r;
    mop_t m;
    s = a % SETS;
    t = a / SETS;
    way = -1;
    for (int i = 0; i < WAYS; i++)
      if (way < 0 && m_valid[s][i] && m_tag[s][i] == t) way = i;
    r.hit = (way >= 0);
    r.dop = 0;
    r.vo  = 1;
    if (r.hit) m_hits++;
    else begin
      m_misses++;
      for (int i = 0; i < WAYS; i++)
        if (way < 0 && !m_valid[s][i]) way = i;
      if (way < 0) begin
        way = 0;
        for (int i = 1; i < WAYS; i++)
          if (m_stamp[s][i] < m_stamp[s][way]) way = i;
      end
      r.vo = m_valid[s][way];
      if (m_valid[s][way] && m_dirty[s][way]) begin
        r.dop  = 1;
        m.we   = 1;
        m.addr = m_tag[s][way] * SETS + s;
        m.data = m_data[s][way];
        mop_q.push_back(m);
        ref_mem[m.addr] = DATA_W'(m.data);
      end
      if (!we) begin
        m.we   = 0;
        m.addr = a;
        m.data = 0;
        mop_q.push_back(m);
        m_data[s][way]  = int'(ref_mem[a]);
        m_dirty[s][way] = 0;
      end
      m_valid[s][way] = 1;
      m_tag[s][way]   = t;
    end
    if (we) begin
      m_data[s][way]  = d;
      m_dirty[s][way] = 1;
    end
    r.rdata = m_data[s][way];
    r.way   = way;
    now++;
    m_stamp[s][way] = now;
    exp_q.push_back(r);
    eh = r.hit;
  endtask

  // Backing memory: serves requests after a random wait, checks each against the model.
  int  wait_cnt = 0;
  int  max_delay = 0;
  bit  mem_hold = 0;
  int  mop_count = 0;
  int  last_wb_addr = -1, last_wb_data = -1, last_rf_addr = -1, last_mem_we = -1;
  mop_t mexp;

  always @(negedge clock) begin
    mem_ack = 1'b0;
    if (!reset && mem_req && !mem_hold) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        mop_count++;
        if (mop_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got request addr %0d we %0d, expected none", mem_addr, mem_we);
        end else begin
          mexp = mop_q.pop_front();
          chk("mem_we", int'(mem_we), int'(mexp.we));
          chk("mem_addr", int'(mem_addr), mexp.addr);
          if (mexp.we) chk("mem_wdata", int'(mem_wdata), mexp.data);
        end
        last_mem_we = int'(mem_we);
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          last_wb_addr = int'(mem_addr);
          last_wb_data = int'(mem_wdata);
        end else begin
          mem_rdata = mem[mem_addr];
          last_rf_addr = int'(mem_addr);
        end
        mem_ack = 1'b1;
        wait_cnt = $urandom_range(0, max_delay);
      end
    end
  end

  // Response compare process.
  resp_t cexp;
  int last_rdata, last_hit, last_vo, last_dirty, last_way;

  always @(negedge clock) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got resp_valid=1, expected no response");
      end else begin
        cexp = exp_q.pop_front();
        chk("rdata", int'(rdata), cexp.rdata);
        chk("hit", int'(hit), int'(cexp.hit));
        chk("valid_o", int'(valid_o), int'(cexp.vo));
        chk("dirty_o", int'(dirty_o), int'(cexp.dop));
        chk("lru_way", int'(lru_way), cexp.way);
      end
      last_rdata = int'(rdata);
      last_hit   = int'(hit);
      last_vo    = int'(valid_o);
      last_dirty = int'(dirty_o);
      last_way   = int'(lru_way);
    end
  end

  task automatic do_req(input bit we, input int a, input int d);
    int n;
    bit eh;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1;
    wren      = we;
    address   = ADDR_W'(a);
    wdata     = DATA_W'(d);
    model_access(we, a, d, eh);
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 100);
    if (!resp_valid) chk("resp_timeout", 0, 1);
    else if (eh) chk("hit_latency", n, 2);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    model_reset();
    wait_cnt = 0;
    mem_hold = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  int mc0, n;

  initial begin
    for (int i = 0; i < NADDR; i++) begin
      mem[i] = DATA_W'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16] = 3'b101;
    ref_mem[16] = 3'b101;
    @(negedge clock);
    do_reset();

    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_counts", int'(hit_count) + int'(miss_count), 0);

    // 1: read miss with refill, then hit
    max_delay = 1;
    do_req(0, 16, 0);
    chk("t1_refill_addr", last_rf_addr, 16);
    chk("t1_refill_we", last_mem_we, 0);
    chk("t1_rdata", last_rdata, 5);
    chk("t1_hit", last_hit, 0);
    mc0 = mop_count;
    do_req(0, 16, 0);
    chk("t1_rehit", last_hit, 1);
    chk("t1_rehit_rdata", last_rdata, 5);
    chk("t1_no_mem", mop_count, mc0);
`ifdef CACHE_STATS_EN
    chk("t6_hit_count", int'(hit_count), 1);
    chk("t6_miss_count", int'(miss_count), 1);
`else
    chk("t6_hit_count", int'(hit_count), 0);
    chk("t6_miss_count", int'(miss_count), 0);
`endif

    // 2: write miss allocates without memory traffic
    mc0 = mop_count;
    do_req(1, 1, 4);
    chk("t2_hit", last_hit, 0);
    chk("t2_no_mem", mop_count, mc0);
    do_req(0, 1, 0);
    chk("t2_read_hit", last_hit, 1);
    chk("t2_read_data", last_rdata, 4);

    // 3: dirty victim writeback before refill
    do_reset();
    do_req(1, 1, 4);
    do_req(1, 9, 1);
    do_req(0, 9, 0);
    chk("t3_hit", last_hit, 1);
    do_req(0, 5, 0);
    chk("t3_wb_addr", last_wb_addr, 1);
    chk("t3_wb_data", last_wb_data, 4);
    chk("t3_refill_addr", last_rf_addr, 5);
    chk("t3_dirty_o", last_dirty, 1);
    chk("t3_way", last_way, 0);

    // 4: LRU replacement order
    do_reset();
    do_req(0, 1, 0);
    do_req(0, 9, 0);
    do_req(0, 1, 0);
    do_req(0, 17, 0);
    chk("t4_miss", last_hit, 0);
    chk("t4_victim_way", last_way, 1);
    do_req(0, 1, 0);
    chk("t4_still_hit", last_hit, 1);

    // 5: reset during a pending refill
    do_reset();
    mem_hold = 1;
    req_valid = 1'b1;
    wren = 1'b0;
    address = 5'd16;
    @(posedge clock);
    #1 req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("t5_pending_req", int'(mem_req), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("t5_req_dropped", int'(mem_req), 0);
    chk("t5_ready", int'(req_ready), 1);
    @(negedge clock);
    model_reset();
    mem_hold = 0;
    wait_cnt = 0;
    reset = 1'b0;
    do_req(0, 16, 0);
    chk("t5_miss_after", last_hit, 0);
    chk("t5_rdata_after", last_rdata, 5);

    // Randomized traffic
    do_reset();
    max_delay = 3;
    for (int i = 0; i < 400; i++) begin
      do_req($urandom_range(0, 1), $urandom_range(0, NADDR - 1), $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) @(negedge clock);
    end

`ifdef CACHE_STATS_EN
    chk("rand_hit_count", int'(hit_count), m_hits);
    chk("rand_miss_count", int'(miss_count), m_misses);
`else
    chk("rand_hit_count", int'(hit_count), 0);
    chk("rand_miss_count", int'(miss_count), 0);
`endif
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mop_q_drained", mop_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
